// File: rtl/axi2apb_cmd_queue_if.sv
// AXI write/read address channels feeding the AXI-to-APB command queue.
interface axi2apb_cmd_queue_if #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ID_WIDTH-1:0]   AWID;
    logic [AXI_ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]                AWLEN;
    logic [2:0]                AWSIZE;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;

    logic [AXI_ID_WIDTH-1:0]   ARID;
    logic [AXI_ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  AWREADY, ARREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output AWREADY, ARREADY
    );
endinterface

// File: rtl/axi2apb_cmd_queue.sv
// AW/AR arbitration and command FIFO for the AXI-to-APB bridge.
// Define AXI2APB_CMD_BURST_EN to expand INCR bursts into per-beat APB addresses.
module axi2apb_cmd_queue #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int CMD_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    axi2apb_cmd_queue_if.slave            axi,
    input  logic                          finish_wr,
    input  logic                          finish_rd,
    output logic                          cmd_empty,
    output logic                          cmd_read,
    output logic [AXI_ID_WIDTH-1:0]       cmd_id,
    output logic [APB_ADDR_WIDTH+3:0]     cmd_addr,
    output logic                          cmd_err,
    output logic                          cmd_last,
    output logic [$clog2(CMD_DEPTH):0]    cmd_count
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CA_W  = APB_ADDR_WIDTH + 4;
    localparam logic [2:0] LEGAL_SIZE = 3'($clog2(APB_DATA_WIDTH / 8));

    logic [AXI_ID_WIDTH-1:0] id_mem   [CMD_DEPTH];
    logic [CA_W-1:0]         addr_mem [CMD_DEPTH];
    logic                    err_mem  [CMD_DEPTH];
    logic                    read_mem [CMD_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             last_rd;
    logic             full, grant_rd, push, pop_beat, retire;

    logic [AXI_ID_WIDTH-1:0] push_id;
    logic [CA_W-1:0]         push_addr;
    logic [7:0]              push_len;
    logic [2:0]              push_size;
    logic [1:0]              push_burst;
    logic                    push_err;
    logic                    unused_bits;

    // Ties and idle both favour the direction that did not push last.
    assign grant_rd = (axi.ARVALID == axi.AWVALID) ? ~last_rd : axi.ARVALID;
    assign full     = (count == (PTR_W+1)'(CMD_DEPTH));
    assign axi.ARREADY = grant_rd & ~full;
    assign axi.AWREADY = ~grant_rd & ~full;
    assign push = grant_rd ? (axi.ARVALID & ~full) : (axi.AWVALID & ~full);

    assign push_id    = grant_rd ? axi.ARID              : axi.AWID;
    assign push_addr  = grant_rd ? axi.ARADDR[CA_W-1:0]  : axi.AWADDR[CA_W-1:0];
    assign push_len   = grant_rd ? axi.ARLEN             : axi.AWLEN;
    assign push_size  = grant_rd ? axi.ARSIZE            : axi.AWSIZE;
    assign push_burst = grant_rd ? axi.ARBURST           : axi.AWBURST;

    assign unused_bits = ^{axi.AWADDR[AXI_ADDR_WIDTH-1:CA_W],
                           axi.ARADDR[AXI_ADDR_WIDTH-1:CA_W], push_burst};

    assign cmd_empty = (count == '0);
    assign cmd_count = count;
    assign cmd_read  = ~cmd_empty & read_mem[rd_ptr];
    assign cmd_id    = cmd_empty ? '0 : id_mem[rd_ptr];
    assign cmd_err   = ~cmd_empty & err_mem[rd_ptr];

    assign pop_beat = ~cmd_empty & (cmd_read ? finish_rd : finish_wr);
    assign retire   = pop_beat & cmd_last;

`ifdef AXI2APB_CMD_BURST_EN
    logic [7:0] len_mem  [CMD_DEPTH];
    logic [2:0] size_mem [CMD_DEPTH];
    logic [7:0] beat;
    logic [7:0] head_len;

    // Only INCR may carry more than one beat.
    assign push_err = (push_size != LEGAL_SIZE) | ((push_burst != 2'b01) & (push_len != 8'd0));
    assign head_len = cmd_empty ? 8'd0 : len_mem[rd_ptr];
    assign cmd_last = (beat == head_len);
    assign cmd_addr = cmd_empty ? '0
                    : addr_mem[rd_ptr] + (CA_W'(beat) << size_mem[rd_ptr]);

    always_ff @(posedge clk) begin
        if (push) begin
            len_mem[wr_ptr]  <= push_len;
            size_mem[wr_ptr] <= push_size;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            beat <= 8'd0;
        else if (retire)
            beat <= 8'd0;
        else if (pop_beat)
            beat <= beat + 8'd1;
    end
`else
    assign push_err = (push_size != LEGAL_SIZE) | (push_len != 8'd0);
    assign cmd_last = 1'b1;
    assign cmd_addr = cmd_empty ? '0 : addr_mem[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]   <= push_id;
            addr_mem[wr_ptr] <= push_addr;
            err_mem[wr_ptr]  <= push_err;
            read_mem[wr_ptr] <= grant_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_rd <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                last_rd <= grant_rd;
            end
            if (retire)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_axi2apb_cmd_queue.sv
// Directed bench for axi2apb_cmd_queue with hand-computed expectations.
module tb_axi2apb_cmd_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        finish_wr, finish_rd;
    logic        cmd_empty, cmd_read, cmd_err, cmd_last;
    logic [5:0]  cmd_id;
    logic [15:0] cmd_addr;
    logic [2:0]  cmd_count;

    int n_checks = 0;
    int n_fail   = 0;

    axi2apb_cmd_queue_if #(.AXI_ID_WIDTH(6), .AXI_ADDR_WIDTH(32)) axi ();

    axi2apb_cmd_queue #(
        .AXI_ID_WIDTH(6), .AXI_ADDR_WIDTH(32), .APB_ADDR_WIDTH(12),
        .APB_DATA_WIDTH(32), .CMD_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .axi(axi),
        .finish_wr(finish_wr), .finish_rd(finish_rd),
        .cmd_empty(cmd_empty), .cmd_read(cmd_read), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_err(cmd_err), .cmd_last(cmd_last),
        .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic valid);
        axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len;
        axi.ARSIZE = size; axi.ARBURST = burst; axi.ARVALID = valid;
    endtask

    task automatic set_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic valid);
        axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = len;
        axi.AWSIZE = size; axi.AWBURST = burst; axi.AWVALID = valid;
    endtask

    task automatic check_head(input string tag, input logic rd, input logic [5:0] id,
                              input logic [15:0] addr, input logic err);
        check({tag, ".empty"}, cmd_empty, 1'b0);
        check({tag, ".read"},  cmd_read,  rd);
        check({tag, ".id"},    cmd_id,    id);
        check({tag, ".addr"},  cmd_addr,  addr);
        check({tag, ".err"},   cmd_err,   err);
    endtask

    task automatic pulse_finish(input logic rd);
        if (rd) finish_rd = 1'b1; else finish_wr = 1'b1;
        tick();
        finish_rd = 1'b0;
        finish_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        finish_wr = 1'b0;
        finish_rd = 1'b0;
        set_ar(6'd0, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
        set_aw(6'd0, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        check("rst.empty",   cmd_empty, 1'b1);
        check("rst.count",   cmd_count, 3'd0);
        check("rst.read",    cmd_read,  1'b0);
        check("rst.id",      cmd_id,    6'd0);
        check("rst.addr",    cmd_addr,  16'h0);
        check("rst.err",     cmd_err,   1'b0);
        check("rst.last",    cmd_last,  1'b1);
        check("rst.arready", axi.ARREADY, 1'b1);
        check("rst.awready", axi.AWREADY, 1'b0);

        // Single legal read
        set_ar(6'd5, 32'h0000_1234, 8'd0, 3'd2, 2'b01, 1'b1);
        #1;
        check("single.arready", axi.ARREADY, 1'b1);
        check("single.awready", axi.AWREADY, 1'b0);
        tick();
        axi.ARVALID = 1'b0;
        check_head("single", 1'b1, 6'd5, 16'h1234, 1'b0);
        check("single.count", cmd_count, 3'd1);
        check("single.last",  cmd_last,  1'b1);
        pulse_finish(1'b0);
        check("wrongdir.count", cmd_count, 3'd1);
        pulse_finish(1'b1);
        check("single.retired", cmd_empty, 1'b1);
        pulse_finish(1'b1);
        check("empty_finish.count", cmd_count, 3'd0);

        // Contention from reset: R, W, R, W then full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ar(6'd1, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 1'b1);
        set_aw(6'd2, 32'h0000_0200, 8'd0, 3'd2, 2'b01, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont%0d.arready", i), axi.ARREADY, (i % 2) == 0);
            check($sformatf("cont%0d.awready", i), axi.AWREADY, (i % 2) != 0);
            tick();
        end
        check("full.count",   cmd_count,   3'd4);
        check("full.arready", axi.ARREADY, 1'b0);
        check("full.awready", axi.AWREADY, 1'b0);
        check_head("full.head", 1'b1, 6'd1, 16'h0100, 1'b0);

        // Retire while full: no bypass push in the same cycle
        axi.ARVALID = 1'b0;
        set_aw(6'd3, 32'h0000_0300, 8'd0, 3'd2, 2'b01, 1'b1);
        finish_rd = 1'b1;
        #1;
        check("fullpop1.awready", axi.AWREADY, 1'b0);
        tick();
        finish_rd = 1'b0;
        check("fullpop1.count", cmd_count, 3'd3);
        check_head("fullpop1.head", 1'b0, 6'd2, 16'h0200, 1'b0);
        check("refill.awready", axi.AWREADY, 1'b1);
        tick();
        check("refill.count", cmd_count, 3'd4);
        finish_wr = 1'b1;
        #1;
        check("fullpop2.awready", axi.AWREADY, 1'b0);
        tick();
        finish_wr = 1'b0;
        axi.AWVALID = 1'b0;
        check("fullpop2.count", cmd_count, 3'd3);
        check_head("drain0", 1'b1, 6'd1, 16'h0100, 1'b0);
        pulse_finish(1'b1);
        check_head("drain1", 1'b0, 6'd2, 16'h0200, 1'b0);
        pulse_finish(1'b0);
        check_head("drain2", 1'b0, 6'd3, 16'h0300, 1'b0);
        pulse_finish(1'b0);
        check("drain.empty", cmd_empty, 1'b1);

        // Illegal size on a 32-bit APB
        set_ar(6'd7, 32'h0000_0010, 8'd0, 3'd3, 2'b01, 1'b1);
        tick();
        axi.ARVALID = 1'b0;
        check_head("badsize", 1'b1, 6'd7, 16'h0010, 1'b1);
        pulse_finish(1'b1);
        check("badsize.retired", cmd_empty, 1'b1);

`ifdef AXI2APB_CMD_BURST_EN
        begin
            logic [15:0] exp_addr [4];
            exp_addr[0] = 16'hFFF8; exp_addr[1] = 16'hFFFC;
            exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0004;
            set_aw(6'd4, 32'h0000_FFF8, 8'd3, 3'd2, 2'b01, 1'b1);
            tick();
            axi.AWVALID = 1'b0;
            for (int b = 0; b < 4; b++) begin
                check_head($sformatf("burst%0d", b), 1'b0, 6'd4, exp_addr[b], 1'b0);
                check($sformatf("burst%0d.last", b), cmd_last, b == 3);
                pulse_finish(1'b0);
            end
            check("burst.retired", cmd_empty, 1'b1);
            set_aw(6'd6, 32'h0000_0040, 8'd1, 3'd2, 2'b00, 1'b1);
            tick();
            axi.AWVALID = 1'b0;
            check_head("fixed0", 1'b0, 6'd6, 16'h0040, 1'b1);
            check("fixed0.last", cmd_last, 1'b0);
            pulse_finish(1'b0);
            check_head("fixed1", 1'b0, 6'd6, 16'h0044, 1'b1);
            check("fixed1.last", cmd_last, 1'b1);
            pulse_finish(1'b0);
            check("fixed.retired", cmd_empty, 1'b1);
        end
`else
        set_aw(6'd4, 32'h0000_0020, 8'd3, 3'd2, 2'b01, 1'b1);
        tick();
        axi.AWVALID = 1'b0;
        check_head("badlen", 1'b0, 6'd4, 16'h0020, 1'b1);
        check("badlen.last", cmd_last, 1'b1);
        pulse_finish(1'b0);
        check("badlen.retired", cmd_empty, 1'b1);
`endif

        // Reset with entries queued and finishes in flight
        set_ar(6'd1, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 1'b1);
        set_aw(6'd2, 32'h0000_0200, 8'd0, 3'd2, 2'b01, 1'b1);
        tick();
        tick();
        tick();
        axi.ARVALID = 1'b0;
        axi.AWVALID = 1'b0;
        check("premid.count", cmd_count, 3'd3);
        rst = 1'b1;
        finish_rd = 1'b1;
        finish_wr = 1'b1;
        tick();
        rst = 1'b0;
        finish_rd = 1'b0;
        finish_wr = 1'b0;
        check("midrst.empty", cmd_empty, 1'b1);
        check("midrst.count", cmd_count, 3'd0);
        check("midrst.last",  cmd_last,  1'b1);
        axi.ARVALID = 1'b1;
        axi.AWVALID = 1'b1;
        #1;
        check("midrst.arready", axi.ARREADY, 1'b1);
        check("midrst.awready", axi.AWREADY, 1'b0);
        axi.ARVALID = 1'b0;
        axi.AWVALID = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi2apb_cmd_queue.md
# axi2apb_cmd_queue

Command front-end of the AXI-to-APB bridge. It arbitrates between the AXI write-address (AW) and read-address (AR) channels and queues accepted commands in a parametrised-depth FIFO. It presents the head command to the APB control logic and retires it on `finish_wr` / `finish_rd`. It adds a fair-arbitration state, a fill-level output, a configurable data width for legality checks and, optionally, INCR burst expansion into per-beat APB addresses.

## Interface
- `AXI_ID_WIDTH`, 6, AXI ID width.
- `AXI_ADDR_WIDTH`, 32, AXI address width.
- `APB_ADDR_WIDTH`, 12, APB slave window; `cmd_addr` is `APB_ADDR_WIDTH+4` bits.
- `APB_DATA_WIDTH`, 32, APB data width (32 or 64); the legal AxSIZE is log2(APB_DATA_WIDTH/8).
- `CMD_DEPTH`, 4, queue entries; must be a power of 2, ≥2.
- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset; synchronous, active-high.
- `AWID`/`ARID`  in  AXI_ID_WIDTH  command ID.
- `AWADDR`/`ARADDR`  in  AXI_ADDR_WIDTH  address; only bits [APB_ADDR_WIDTH+3:0] are stored.
- `AWLEN`/`ARLEN`  in  8  burst length − 1.
- `AWSIZE`/`ARSIZE`  in  3  beat size.
- `AWBURST`/`ARBURST`  in  2  burst type.
- `AWVALID`/`ARVALID`  in  1  command valid.
- `AWREADY`/`ARREADY`  out  1  command accepted.
- `finish_wr`, `finish_rd`  in  1  head beat completed on APB.
- `cmd_empty`  out  1  queue empty.
- `cmd_read`  out  1  head is a read.
- `cmd_id`  out  AXI_ID_WIDTH  head ID.
- `cmd_addr`  out  APB_ADDR_WIDTH+4  current beat address.
- `cmd_err`  out  1  head is illegal; the APB side answers SLVERR without an APB access.
- `cmd_last`  out  1  current beat is the last beat of the head.
- `cmd_count`  out  $clog2(CMD_DEPTH)+1  number of occupied entries.

## Operation
- **Grant (combinational)**
  - Both valid: grant the channel opposite to `last_rd`.
  - One valid: grant that channel.
  - Neither valid: grant the read channel if `last_rd` = 0, otherwise the write channel.
- **Ready and push**
  - `ARREADY = grant_rd & ~full`; `AWREADY = ~grant_rd & ~full`. At most one ready is high per cycle.
  - Push = the granted handshake. The entry stores {id, addr[APB_ADDR_WIDTH+3:0], len, err, read}.
  - `last_rd` register: updated to the pushed direction on each push; reset to 0, so reads win the first contention.
- **Error flag**: `err` = (AxSIZE ≠ legal size) | (AxLEN ≠ 0), unless bursts are compiled in (see Configuration).
- **Pop**
  - `pop_beat = ~cmd_empty & (cmd_read ? finish_rd : finish_wr)`.
  - A finish on the wrong direction, or while empty, is ignored.
  - The entry retires on a `pop_beat` with `cmd_last` = 1.
- **Storage**: circular buffer with wrap-around read/write pointers and a counter.
  - `full` = (count == CMD_DEPTH); `cmd_empty` = (count == 0).
  - Simultaneous push and retire: count unchanged, both pointers advance.
- **Full queue**: when full, no push occurs even if a retire happens in the same cycle (no bypass).

## Timing
- **Reset values**: the queue is flushed.
  - `cmd_empty`=1, `cmd_count`=0.
  - `cmd_read`, `cmd_id`, `cmd_addr`, `cmd_err`: 0.
  - `cmd_last`=1; beat counter 0; `last_rd`=0.
  - A reset asserted mid-burst or with a non-empty queue drops every entry the next cycle; in-flight finishes are ignored.
- **Latency**: a push at edge N makes the entry visible (`cmd_empty`=0) after edge N. There is no same-cycle pass-through.
- **Retire**: a retire at edge N presents the next entry (or `cmd_empty`) after edge N. `cmd_count` is registered.
- **Ready**: READY may drop while VALID is held if the grant moves to the other channel. This is legal because the source must keep VALID high.

## Configuration
- Macro: `AXI2APB_CMD_BURST_EN`.
- **Defined**:
  - `err` = (size illegal) | (AxBURST ≠ INCR & AxLEN ≠ 0).
  - The head is expanded into AxLEN+1 beats.
  - A beat counter `beat` (8 bits, reset to 0 on retire) advances on each `pop_beat`.
  - `cmd_addr = head_addr + (beat << size)`, truncated to APB_ADDR_WIDTH+4 bits (modulo wrap).
  - `cmd_last = (beat == head_len)`.
  - Errored bursts still produce AxLEN+1 beats, each with `cmd_err`=1.
- **Undefined**:
  - AxLEN ≠ 0 sets `err`; `cmd_last` is tied to 1 and every `pop_beat` retires.
  - The len field and beat counter are not synthesised.

## Test plan
- **Single read**: reset, then ARVALID with ARADDR=0x0000_1234, ARSIZE=2, ARLEN=0 → ARREADY same cycle; next cycle `cmd_read`=1, `cmd_addr`=0x1234, `cmd_err`=0, `cmd_count`=1; `finish_rd` → `cmd_empty`=1.
- **Contention**: AWVALID and ARVALID held for 4 pushes → order R, W, R, W; `cmd_count` reaches 4, then both READY=0 while full.
- **Full with pop**: queue full, `finish_wr` on a write head while AWVALID=1 → no push that cycle; `cmd_count` 4→3; push on the next cycle.
- **Illegal size/length**: ARSIZE=3 with APB_DATA_WIDTH=32 → `cmd_err`=1. With the macro undefined, AWLEN=3 → `cmd_err`=1 and one `finish_wr` retires the entry.
- **Burst (macro defined)**: AW INCR, AWADDR=0xFFF8, AWSIZE=2, AWLEN=3, APB_ADDR_WIDTH=12 → `cmd_addr` 0xFFF8, 0xFFFC, 0x0000, 0x0004; `cmd_last` high on the 4th beat only; retire after the 4th `finish_wr`.
- **Reset mid-op**: 3 entries queued and burst beat 1 active, `rst` pulsed for one cycle → `cmd_empty`=1, `cmd_count`=0; the next contention grants read first.
